ifu_fetch: RTL and testbench

Instruction-fetch stage of the RV64 pipeline CPU. Owns the architectural fetch PC, issues one instruction-memory read at a time, and presents the returned instruction to the fetch→decode pipeline register through a valid/allow_in handshake. Execute-stage redirects (branches, jumps, traps) override the PC and squash any in-flight or buffered fetch.

---
 rtl/pipeline_pkg.sv | 30 +++
 rtl/ifu_fetch.sv | 114 +++++++++++
 tb/tb_ifu_fetch.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM states, reset PC and the commit_info
// bundle layout used by the fetch stage.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_HOLD = 2'd3
    } fetch_state_e;

    localparam int          COMMIT_W         = 161;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    // commit_info field MSB positions, packed {pc, instr, next_pc, valid}
    localparam int PC_MSB    = 160;
    localparam int INSTR_MSB = 96;
    localparam int NPC_MSB   = 64;
    localparam int VALID_BIT = 0;

    function automatic logic [160:0] pack_commit_info(
        input logic [63:0] pc,
        input logic [31:0] instr,
        input logic [63:0] next_pc,
        input logic        valid
    );
        return {pc, instr, next_pc, valid};
    endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps one imem read in flight and
// buffers the returned word until decode accepts it; redirects squash everything.
module ifu_fetch #(
    parameter logic [63:0] RESET_PC = pipeline_pkg::RESET_PC_DEFAULT,
    parameter int          COMMIT_W = pipeline_pkg::COMMIT_W
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_valid,
    output logic [63:0]         imem_req_addr,
    input  logic                imem_req_ready,
    input  logic                imem_resp_valid,
    input  logic [31:0]         imem_resp_data,
    input  logic                redirect_valid,
    input  logic [63:0]         redirect_pc,
    input  logic                regD_allow_in,
    output logic                fetch_o_valid,
    output logic [63:0]         fetch_o_pc,
    output logic [31:0]         fetch_o_instr,
    output logic [COMMIT_W-1:0] fetch_o_commit_info
);
    import pipeline_pkg::*;

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic         kill_q, kill_d;
    logic [63:0]  buf_pc_q, buf_pc_d;
    logic [31:0]  buf_instr_q, buf_instr_d;
    logic [63:0]  buf_npc_q, buf_npc_d;
    logic         buf_cv_q, buf_cv_d;
    logic [1:0]   unused_redirect_lsb;

    assign unused_redirect_lsb = redirect_pc[1:0];

    assign imem_req_valid = (state_q == FETCH_REQ);
    assign imem_req_addr  = (state_q == FETCH_REQ) ? pc_q : 64'd0;
    // Redirect must block a transfer in the very cycle it arrives.
    assign fetch_o_valid  = (state_q == FETCH_HOLD) && !redirect_valid;

    assign fetch_o_pc          = buf_pc_q;
    assign fetch_o_instr       = buf_instr_q;
    assign fetch_o_commit_info = pack_commit_info(buf_pc_q, buf_instr_q, buf_npc_q, buf_cv_q);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        buf_npc_d   = buf_npc_q;
        buf_cv_d    = buf_cv_q;

        case (state_q)
            FETCH_IDLE: state_d = FETCH_REQ;
            FETCH_REQ: begin
                if (imem_req_ready) begin
                    state_d = FETCH_WAIT;
                    // The request just issued targets the old PC; its reply must be dropped.
                    kill_d  = redirect_valid;
                end
            end
            FETCH_WAIT: begin
                if (imem_resp_valid) begin
                    kill_d = 1'b0;
                    if (redirect_valid || kill_q) begin
                        state_d = FETCH_REQ;
                    end else begin
                        buf_pc_d    = pc_q;
                        buf_instr_d = imem_resp_data;
                        buf_npc_d   = pc_q + 64'd4;
                        buf_cv_d    = 1'b1;
                        state_d     = FETCH_HOLD;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            FETCH_HOLD: begin
                if (redirect_valid) begin
                    state_d = FETCH_REQ;
                end else if (fetch_o_valid && regD_allow_in) begin
                    pc_d    = pc_q + 64'd4;
                    state_d = FETCH_REQ;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase

        if (redirect_valid && (state_q != FETCH_IDLE)) begin
            pc_d = {redirect_pc[63:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= FETCH_IDLE;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            buf_pc_q    <= 64'd0;
            buf_instr_q <= 32'd0;
            buf_npc_q   <= 64'd0;
            buf_cv_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            buf_npc_q   <= buf_npc_d;
            buf_cv_q    <= buf_cv_d;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a per-cycle vector table plus a hand-written
// back-to-back redirect sequence.
module tb_ifu_fetch;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] npc;
        logic        cv;
    } obuf_t;

    typedef struct {
        logic        rst;
        logic        ready;
        logic        rv;
        logic [31:0] rdata;
        logic        redir;
        logic [63:0] rpc;
        logic        allow;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_ov;
        obuf_t       e_buf;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         imem_req_valid;
    logic [63:0]  imem_req_addr;
    logic         imem_req_ready;
    logic         imem_resp_valid;
    logic [31:0]  imem_resp_data;
    logic         redirect_valid;
    logic [63:0]  redirect_pc;
    logic         regD_allow_in;
    logic         fetch_o_valid;
    logic [63:0]  fetch_o_pc;
    logic [31:0]  fetch_o_instr;
    logic [160:0] fetch_o_commit_info;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    vec_t  vecs [40];
    obuf_t bz, ba, bb, bc, bd, be, bf;

    ifu_fetch dut (
        .clk                 (clk),
        .rst                 (rst),
        .imem_req_valid      (imem_req_valid),
        .imem_req_addr       (imem_req_addr),
        .imem_req_ready      (imem_req_ready),
        .imem_resp_valid     (imem_resp_valid),
        .imem_resp_data      (imem_resp_data),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .regD_allow_in       (regD_allow_in),
        .fetch_o_valid       (fetch_o_valid),
        .fetch_o_pc          (fetch_o_pc),
        .fetch_o_instr       (fetch_o_instr),
        .fetch_o_commit_info (fetch_o_commit_info)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obuf_t mkb(input logic [63:0] pc, input logic [31:0] instr,
                                  input logic [63:0] npc, input logic cv);
        obuf_t b;
        b.pc = pc; b.instr = instr; b.npc = npc; b.cv = cv;
        return b;
    endfunction

    function automatic vec_t mkv(input logic r, input logic rdy, input logic rv,
                                 input logic [31:0] rdata, input logic redir,
                                 input logic [63:0] rpc, input logic allow,
                                 input logic e_req, input logic [63:0] e_addr,
                                 input logic e_ov, input obuf_t b);
        vec_t v;
        v.rst = r; v.ready = rdy; v.rv = rv; v.rdata = rdata; v.redir = redir;
        v.rpc = rpc; v.allow = allow; v.e_req = e_req; v.e_addr = e_addr;
        v.e_ov = e_ov; v.e_buf = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [160:0] got, input logic [160:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_in(input logic rdy, input logic rv, input logic [31:0] rdata,
                          input logic redir, input logic [63:0] rpc, input logic allow);
        rst = 1'b1; imem_req_ready = rdy; imem_resp_valid = rv; imem_resp_data = rdata;
        redirect_valid = redir; redirect_pc = rpc; regD_allow_in = allow;
    endtask

    task automatic tick(input string label);
        $display("seq %s: req=%0b addr=%h ov=%0b pc=%h instr=%h", label, imem_req_valid,
                 imem_req_addr, fetch_o_valid, fetch_o_pc, fetch_o_instr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bz = mkb(64'd0, 32'd0, 64'd0, 1'b0);
        ba = mkb(64'h8000_0000, 32'h0000_0013, 64'h8000_0004, 1'b1);
        bb = mkb(64'h8000_0004, 32'h0010_0093, 64'h8000_0008, 1'b1);
        bc = mkb(64'h8000_1000, 32'h0020_0113, 64'h8000_1004, 1'b1);
        bd = mkb(64'h8000_3000, 32'h0000_0013, 64'h8000_3004, 1'b1);
        be = mkb(64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0013, 64'd0, 1'b1);
        bf = ba;

        //                rst rdy rv rdata         rd rpc                     al  req addr                    ov  buf
        vecs[0]  = mkv(0, 0, 0, 32'h0,         0, 64'h0,                  0,  0, 64'h0,                  0, bz);
        vecs[1]  = mkv(1, 0, 0, 32'h0,         0, 64'h0,                  0,  0, 64'h0,                  0, bz);
        vecs[2]  = mkv(1, 1, 0, 32'h0,         0, 64'h0,                  0,  1, 64'h8000_0000,          0, bz);
        vecs[3]  = mkv(1, 0, 1, 32'h0000_0013, 0, 64'h0,                  0,  0, 64'h0,                  0, bz);
        vecs[4]  = mkv(1, 0, 0, 32'h0,         0, 64'h0,                  1,  0, 64'h0,                  1, ba);
        vecs[5]  = mkv(1, 1, 0, 32'h0,         0, 64'h0,                  0,  1, 64'h8000_0004,          0, ba);
        vecs[6]  = mkv(1, 0, 1, 32'h0010_0093, 0, 64'h0,                  0,  0, 64'h0,                  0, ba);
        for (int i = 7; i < 12; i++)
            vecs[i] = mkv(1, 0, 0, 32'h0,      0, 64'h0,                  0,  0, 64'h0,                  1, bb);
        vecs[12] = mkv(1, 0, 0, 32'h0,         0, 64'h0,                  1,  0, 64'h0,                  1, bb);
        vecs[13] = mkv(1, 1, 0, 32'h0,         0, 64'h0,                  0,  1, 64'h8000_0008,          0, bb);
        vecs[14] = mkv(1, 0, 0, 32'h0,         1, 64'h8000_1003,          0,  0, 64'h0,                  0, bb);
        vecs[15] = mkv(1, 0, 0, 32'h0,         0, 64'h0,                  0,  0, 64'h0,                  0, bb);
        vecs[16] = mkv(1, 0, 1, 32'hDEAD_BEEF, 0, 64'h0,                  1,  0, 64'h0,                  0, bb);
        vecs[17] = mkv(1, 1, 0, 32'h0,         0, 64'h0,                  1,  1, 64'h8000_1000,          0, bb);
        vecs[18] = mkv(1, 0, 1, 32'h0020_0113, 0, 64'h0,                  0,  0, 64'h0,                  0, bb);
        vecs[19] = mkv(1, 0, 0, 32'h0,         1, 64'h8000_2000,          1,  0, 64'h0,                  0, bc);
        vecs[20] = mkv(1, 0, 0, 32'h0,         1, 64'h8000_3000,          0,  1, 64'h8000_2000,          0, bc);
        vecs[21] = mkv(1, 1, 0, 32'h0,         0, 64'h0,                  0,  1, 64'h8000_3000,          0, bc);
        vecs[22] = mkv(1, 0, 1, 32'h0000_0013, 0, 64'h0,                  0,  0, 64'h0,                  0, bc);
        vecs[23] = mkv(1, 0, 0, 32'h0,         0, 64'h0,                  1,  0, 64'h0,                  1, bd);
        vecs[24] = mkv(1, 1, 0, 32'h0,         1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1, 64'h8000_3004,          0, bd);
        vecs[25] = mkv(1, 0, 1, 32'h0000_0BAD, 0, 64'h0,                  0,  0, 64'h0,                  0, bd);
        vecs[26] = mkv(1, 1, 0, 32'h0,         0, 64'h0,                  0,  1, 64'hFFFF_FFFF_FFFF_FFFC, 0, bd);
        vecs[27] = mkv(1, 0, 1, 32'h0000_0013, 0, 64'h0,                  0,  0, 64'h0,                  0, bd);
        vecs[28] = mkv(1, 0, 0, 32'h0,         0, 64'h0,                  1,  0, 64'h0,                  1, be);
        vecs[29] = mkv(1, 1, 0, 32'h0,         0, 64'h0,                  0,  1, 64'h0,                  0, be);
        vecs[30] = mkv(1, 0, 1, 32'h0000_0077, 1, 64'h8000_4000,          0,  0, 64'h0,                  0, be);
        vecs[31] = mkv(1, 1, 0, 32'h0,         0, 64'h0,                  0,  1, 64'h8000_4000,          0, be);
        vecs[32] = mkv(1, 0, 0, 32'h0,         0, 64'h0,                  0,  0, 64'h0,                  0, be);
        vecs[33] = mkv(0, 0, 0, 32'h0,         0, 64'h0,                  0,  0, 64'h0,                  0, be);
        vecs[34] = mkv(1, 0, 1, 32'h0000_0055, 1, 64'h9000_0000,          0,  0, 64'h0,                  0, bz);
        vecs[35] = mkv(1, 0, 1, 32'h0000_0066, 0, 64'h0,                  0,  1, 64'h8000_0000,          0, bz);
        vecs[36] = mkv(1, 1, 0, 32'h0,         0, 64'h0,                  0,  1, 64'h8000_0000,          0, bz);
        vecs[37] = mkv(1, 0, 1, 32'h0000_0013, 0, 64'h0,                  0,  0, 64'h0,                  0, bz);
        vecs[38] = mkv(1, 0, 0, 32'h0,         0, 64'h0,                  1,  0, 64'h0,                  1, bf);
        vecs[39] = mkv(1, 0, 0, 32'h0,         0, 64'h0,                  0,  1, 64'h8000_0004,          0, bf);

        rst = 1'b0;
        set_in(0, 0, 32'h0, 0, 64'h0, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            rst             = vecs[i].rst;
            imem_req_ready  = vecs[i].ready;
            imem_resp_valid = vecs[i].rv;
            imem_resp_data  = vecs[i].rdata;
            redirect_valid  = vecs[i].redir;
            redirect_pc     = vecs[i].rpc;
            regD_allow_in   = vecs[i].allow;
            @(negedge clk);
            chk($sformatf("v%0d_req_valid", i), imem_req_valid, vecs[i].e_req);
            if (vecs[i].e_req)
                chk($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_o_valid", i), fetch_o_valid, vecs[i].e_ov);
            chk($sformatf("v%0d_o_pc", i), fetch_o_pc, vecs[i].e_buf.pc);
            chk($sformatf("v%0d_o_instr", i), fetch_o_instr, vecs[i].e_buf.instr);
            chk($sformatf("v%0d_commit_info", i), fetch_o_commit_info,
                {vecs[i].e_buf.pc, vecs[i].e_buf.instr, vecs[i].e_buf.npc, vecs[i].e_buf.cv});
            $display("vec %0d: req=%0b addr=%h ov=%0b pc=%h instr=%h", i, imem_req_valid,
                     imem_req_addr, fetch_o_valid, fetch_o_pc, fetch_o_instr);
            @(posedge clk);
            #1;
        end

        // Back-to-back redirects while a request is outstanding; last target wins.
        set_in(1, 0, 32'h0, 0, 64'h0, 0);
        @(negedge clk);
        chk("seq_req0", imem_req_valid, 1'b1);
        chk("seq_addr0", imem_req_addr, 64'h8000_0004);
        tick("issue");
        set_in(0, 0, 32'h0, 1, 64'h9000_0000, 0);
        @(negedge clk);
        chk("seq_redir1_ov", fetch_o_valid, 1'b0);
        tick("redir1");
        set_in(0, 0, 32'h0, 1, 64'h9000_0101, 1);
        @(negedge clk);
        chk("seq_redir2_req", imem_req_valid, 1'b0);
        tick("redir2");
        set_in(0, 1, 32'h0000_1111, 0, 64'h0, 1);
        @(negedge clk);
        chk("seq_drop_req", imem_req_valid, 1'b0);
        chk("seq_drop_ov", fetch_o_valid, 1'b0);
        tick("drop");
        set_in(1, 0, 32'h0, 0, 64'h0, 0);
        @(negedge clk);
        chk("seq_req1", imem_req_valid, 1'b1);
        chk("seq_addr1", imem_req_addr, 64'h9000_0100);
        tick("refetch");
        set_in(0, 1, 32'h0030_0193, 0, 64'h0, 0);
        @(negedge clk);
        chk("seq_resp_ov", fetch_o_valid, 1'b0);
        tick("resp");
        set_in(0, 0, 32'h0, 0, 64'h0, 1);
        @(negedge clk);
        chk("seq_hold_ov", fetch_o_valid, 1'b1);
        chk("seq_hold_pc", fetch_o_pc, 64'h9000_0100);
        chk("seq_hold_ci", fetch_o_commit_info,
            {64'h9000_0100, 32'h0030_0193, 64'h9000_0104, 1'b1});
        tick("transfer");
        set_in(0, 0, 32'h0, 0, 64'h0, 0);
        @(negedge clk);
        chk("seq_req2", imem_req_valid, 1'b1);
        chk("seq_addr2", imem_req_addr, 64'h9000_0104);
        tick("next");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
